// File: rtl/scan_mux_pkg.sv
// Shared types and constants for the scan_mux channel multiplexer.
package scan_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_mux_dwell_cnt.sv
// Dwell counter for scan_mux: counts 0..DWELL-1 while the scan is running
// and pulses adv_o on the last count so the scan channel moves on.
module scan_mux_dwell_cnt #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic run_i,
  output logic adv_o
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0] cnt_q;

  assign adv_o = run_i && (cnt_q == CW'(DWELL - 1));

  // Count while running; restart from zero on reset, on clear and after each advance.
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      cnt_q <= '0;
    end else if (run_i) begin
      cnt_q <= adv_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/scan_mux.sv
// scan_mux: registered N_CH-to-1 channel multiplexer with manual select and
// an auto-scan mode that holds each channel for DWELL cycles.
// Optional feature: define SCAN_MUX_MASK_EN to add the ch_mask port, which
// restricts the auto-scan to channels whose mask bit is set.
//
//   state  | meaning
//   IDLE   | en low: output zero/invalid, channel indices held
//   MANUAL | y follows the channel picked by sel
//   SCAN   | y steps through the (enabled) channels, DWELL cycles each
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int N_CH  = 8,
  parameter int W     = 8,
  parameter int DWELL = 4,
  localparam int SW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              mode,
  input  logic [SW-1:0]     sel,
  input  logic [N_CH*W-1:0] d,
`ifdef SCAN_MUX_MASK_EN
  input  logic [N_CH-1:0]   ch_mask,
`endif
  output logic [W-1:0]      y,
  output logic              y_valid,
  output logic [SW-1:0]     cur_ch,
  output logic              wrap
);

  state_e          state_q, state_d;
  logic [W-1:0]    y_q, y_d;
  logic            y_valid_q, y_valid_d;
  logic [SW-1:0]   cur_ch_q, cur_ch_d;
  logic [SW-1:0]   scan_ch_q, scan_ch_d;
  logic            wrap_q, wrap_d;

  logic [W-1:0]    ch_data [N_CH];
  logic [N_CH-1:0] mask_w;
  logic            mask_any;
  logic            sel_legal;
  logic            scan_run;
  logic            dwell_adv;
  logic [SW:0]     entry_hit;
  logic [SW:0]     adv_hit;

  // Circular search for the first set mask bit at or after 'from'
  // (from may be N_CH); the MSB of the result flags that one was found.
  function automatic logic [SW:0] first_set(input logic [N_CH-1:0] m, input int from);
    logic [SW:0]   r;
    logic [SW-1:0] pos;
    int            idx;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = from + i;
      if (idx >= N_CH) idx = idx - N_CH;
      pos = SW'(idx);
      if (m[pos]) r = {1'b1, pos};
    end
    return r;
  endfunction

`ifdef SCAN_MUX_MASK_EN
  assign mask_w = ch_mask;
`else
  assign mask_w = '1;
`endif

  assign mask_any  = |mask_w;
  assign sel_legal = (int'(sel) < N_CH);
  assign state_d   = !en ? IDLE : ((mode == MODE_SCAN) ? SCAN : MANUAL);
  assign scan_run  = (state_q == SCAN) && (state_d == SCAN);
  assign entry_hit = first_set(mask_w, sel_legal ? int'(sel) : 0);
  assign adv_hit   = first_set(mask_w, int'(scan_ch_q) + 1);

  // Unpack the channel bus into an indexable array.
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      ch_data[k] = d[k*W +: W];
    end
  end

  scan_mux_dwell_cnt #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk    (clk),
    .reset  (reset),
    .clear_i(!scan_run),
    .run_i  (scan_run),
    .adv_o  (dwell_adv)
  );

  // Next output values for the state being entered on this edge.
  always_comb begin
    y_d       = '0;
    y_valid_d = 1'b0;
    cur_ch_d  = cur_ch_q;
    wrap_d    = 1'b0;
    scan_ch_d = scan_ch_q;
    unique case (state_d)
      MANUAL: begin
        cur_ch_d = sel;
        if (sel_legal) begin
          y_d       = ch_data[sel];
          y_valid_d = 1'b1;
        end
      end
      SCAN: begin
        if (state_q != SCAN) begin
          if (entry_hit[SW]) scan_ch_d = entry_hit[SW-1:0];
        end else if (dwell_adv && adv_hit[SW]) begin
          scan_ch_d = adv_hit[SW-1:0];
          // Landing at or below the old index means the search passed N_CH-1.
          wrap_d    = (adv_hit[SW-1:0] <= scan_ch_q);
        end
        if (mask_any) begin
          y_d       = ch_data[scan_ch_d];
          y_valid_d = 1'b1;
          cur_ch_d  = scan_ch_d;
        end
      end
      default: ;
    endcase
  end

  // State and registered outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      cur_ch_q  <= '0;
      scan_ch_q <= '0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      cur_ch_q  <= cur_ch_d;
      scan_ch_q <= scan_ch_d;
      wrap_q    <= wrap_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign cur_ch  = cur_ch_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: three instances (6ch/dwell3, 8ch/dwell1, 8ch/dwell4)
// share one stimulus stream and are compared every cycle against a
// behavioural model; directed sequences cover the documented scenarios.
module tb_scan_mux;

  localparam int NCH [3] = '{6, 8, 8};
  localparam int DW  [3] = '{3, 1, 4};

  logic            clk;
  logic            reset;
  logic            en;
  logic            mode;
  logic [2:0]      sel;
  logic [63:0]     d_all;
  logic [7:0]      mask8;
  logic [2:0][7:0] y_o;
  logic [2:0]      yv_o;
  logic [2:0][2:0] cur_o;
  logic [2:0]      wrap_o;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int st;   // 0 idle, 1 manual, 2 scan
    int ch;
    int age;
    int y;
    bit yv;
    int cur;
    bit wrap;
  } mdl_t;

  mdl_t m [3];

  scan_mux #(.N_CH(6), .W(8), .DWELL(3)) dut_a (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel), .d(d_all[47:0]),
`ifdef SCAN_MUX_MASK_EN
    .ch_mask(mask8[5:0]),
`endif
    .y(y_o[0]), .y_valid(yv_o[0]), .cur_ch(cur_o[0]), .wrap(wrap_o[0])
  );

  scan_mux #(.N_CH(8), .W(8), .DWELL(1)) dut_b (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel), .d(d_all),
`ifdef SCAN_MUX_MASK_EN
    .ch_mask(mask8),
`endif
    .y(y_o[1]), .y_valid(yv_o[1]), .cur_ch(cur_o[1]), .wrap(wrap_o[1])
  );

  scan_mux #(.N_CH(8), .W(8), .DWELL(4)) dut_c (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sel(sel), .d(d_all),
`ifdef SCAN_MUX_MASK_EN
    .ch_mask(mask8),
`endif
    .y(y_o[2]), .y_valid(yv_o[2]), .cur_ch(cur_o[2]), .wrap(wrap_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: one clock edge of a scan_mux with n channels and dwell dw.
  function automatic mdl_t mdl_step(mdl_t mi, int n, int dw, bit rst, bit en_v, bit mode_v,
                                    int sel_v, logic [63:0] dv, logic [7:0] mk);
    mdl_t r;
    int   nst;
    int   nx;
    bit   any;
    r      = mi;
    r.wrap = 1'b0;
    if (rst) begin
      r.st = 0; r.ch = 0; r.age = 0; r.y = 0; r.yv = 0; r.cur = 0;
      return r;
    end
    nst = !en_v ? 0 : (mode_v ? 2 : 1);
    any = 1'b0;
    for (int k = 0; k < n; k++) if (mk[k]) any = 1'b1;
    if (nst == 0) begin
      r.y = 0; r.yv = 0;
    end else if (nst == 1) begin
      r.cur = sel_v;
      if (sel_v < n) begin
        r.y = int'(dv[sel_v*8 +: 8]); r.yv = 1;
      end else begin
        r.y = 0; r.yv = 0;
      end
    end else begin
      if (mi.st != 2) begin
        r.age = 0;
        if (any) begin
          r.ch = (sel_v < n) ? sel_v : 0;
          while (!mk[r.ch]) r.ch = (r.ch + 1) % n;
        end
      end else begin
        r.age = mi.age + 1;
        if (r.age == dw) begin
          r.age = 0;
          if (any) begin
            nx = mi.ch;
            do begin
              nx = nx + 1;
              if (nx == n) begin
                nx = 0;
                r.wrap = 1'b1;
              end
            end while (!mk[nx]);
            r.ch = nx;
          end
        end
      end
      if (any) begin
        r.y = int'(dv[r.ch*8 +: 8]); r.yv = 1; r.cur = r.ch;
      end else begin
        r.y = 0; r.yv = 0;
      end
    end
    r.st = nst;
    return r;
  endfunction

  task automatic cmp_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("y[%0d]", i),      32'(y_o[i]),   32'(m[i].y));
      chk($sformatf("valid[%0d]", i),  32'(yv_o[i]),  32'(m[i].yv));
      chk($sformatf("cur_ch[%0d]", i), 32'(cur_o[i]), 32'(m[i].cur));
      chk($sformatf("wrap[%0d]", i),   32'(wrap_o[i]), 32'(m[i].wrap));
    end
  endtask

  task automatic cycle();
    logic [7:0] mk;
`ifdef SCAN_MUX_MASK_EN
    mk = mask8;
`else
    mk = 8'hFF;
`endif
    @(posedge clk);
    for (int i = 0; i < 3; i++)
      m[i] = mdl_step(m[i], NCH[i], DW[i], reset, en, mode, int'(sel), d_all, mk);
    #1;
    cmp_all();
  endtask

  initial begin
    int exp_a [7] = '{4, 4, 4, 5, 5, 5, 0};
    int exp_c [5] = '{2, 2, 2, 2, 3};
    int exp_m [4] = '{0, 2, 7, 0};

    for (int i = 0; i < 3; i++) m[i] = '{0, 0, 0, 0, 0, 0, 0};
    reset = 1'b1; en = 1'b0; mode = 1'b0; sel = 3'd0; d_all = '0; mask8 = 8'hFF;
    cycle();
    cycle();
    chk("rst_y",     32'(y_o[0]),   32'h0);
    chk("rst_valid", 32'(yv_o[2]),  32'h0);
    chk("rst_cur",   32'(cur_o[1]), 32'h0);

    // Manual select, legal and out-of-range.
    for (int k = 0; k < 8; k++) d_all[k*8 +: 8] = 8'h10 + 8'(k);
    reset = 1'b0; en = 1'b1; mode = 1'b0; sel = 3'd5;
    cycle();
    chk("man_y",     32'(y_o[1]),   32'h15);
    chk("man_valid", 32'(yv_o[1]),  32'h1);
    chk("man_cur",   32'(cur_o[1]), 32'h5);
    sel = 3'd7;
    cycle();
    chk("man_oor_y",     32'(y_o[0]),  32'h0);
    chk("man_oor_valid", 32'(yv_o[0]), 32'h0);
    chk("man_oor_cur",   32'(cur_o[0]), 32'h7);

    // Scan entry at sel=4 on the 6-channel instance: wrap 5 -> 0.
    sel = 3'd4; mode = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cycle();
      chk("scan6_y",    32'(y_o[0]),    32'(8'h10 + 8'(exp_a[i])));
      chk("scan6_wrap", 32'(wrap_o[0]), (i == 6) ? 32'h1 : 32'h0);
    end

    // Drop en mid-dwell, then re-enter at sel=2 with a full dwell.
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("idle_y",     32'(y_o[2]),  32'h0);
      chk("idle_valid", 32'(yv_o[2]), 32'h0);
    end
    en = 1'b1; sel = 3'd2;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("reentry_y", 32'(y_o[2]), 32'(8'h10 + 8'(exp_c[i])));
    end

    // Reset on the edge that would produce the wrap pulse.
    mode = 1'b0;
    cycle();
    mode = 1'b1; sel = 3'd5;
    for (int i = 0; i < 3; i++) cycle();
    chk("prewrap_cur", 32'(cur_o[0]), 32'h5);
    reset = 1'b1;
    cycle();
    chk("rstwrap_wrap",  32'(wrap_o[0]), 32'h0);
    chk("rstwrap_y",     32'(y_o[0]),    32'h0);
    chk("rstwrap_valid", 32'(yv_o[0]),   32'h0);
    chk("rstwrap_cur",   32'(cur_o[0]),  32'h0);
    reset = 1'b0;
    cycle();

`ifdef SCAN_MUX_MASK_EN
    mode = 1'b0; sel = 3'd0; mask8 = 8'b1000_0101;
    cycle();
    mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("mask_y",    32'(y_o[1]),    32'(8'h10 + 8'(exp_m[i])));
      chk("mask_wrap", 32'(wrap_o[1]), (i == 3) ? 32'h1 : 32'h0);
    end
    mask8 = 8'h00;
    cycle();
    chk("mask0_valid", 32'(yv_o[1]),   32'h0);
    chk("mask0_wrap",  32'(wrap_o[1]), 32'h0);
    mask8 = 8'hFF;
    cycle();
`endif

    // Randomised traffic checked by the model every cycle.
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      if (en) begin
        if ($urandom_range(0, 14) == 0) en = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        en = 1'b1;
      end
      if ($urandom_range(0, 11) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) sel = 3'($urandom);
      d_all = {$urandom, $urandom};
`ifdef SCAN_MUX_MASK_EN
      if ($urandom_range(0, 29) == 0)
        mask8 = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
`endif
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 Parameter N_CH, default 8, number of input channels; legal range 2..64, non-power-of-two allowed.
REQ-002 Parameter W, default 8, bits per channel.
REQ-003 Parameter DWELL, default 4, cycles each channel is held in scan mode; legal range 1..256.
REQ-004 Derived constant SW = max(1, $clog2(N_CH)), select width.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  block enable; 0 forces idle.
REQ-008 mode  input  1  0 = manual select, 1 = auto-scan.
REQ-009 sel  input  SW  manual channel select.
REQ-010 d  input  N_CH*W  packed channel data; channel k occupies d[k*W +: W].
REQ-011 y  output  W  registered selected data.
REQ-012 y_valid  output  1  y holds data from a legal, enabled channel.
REQ-013 cur_ch  output  SW  channel index that produced the current y.
REQ-014 wrap  output  1  one-cycle pulse when scan advances from the last channel back to the first.

Function
REQ-015 States: IDLE, MANUAL, SCAN; next state is IDLE if en=0, else MANUAL if mode=0, else SCAN, evaluated every cycle.
REQ-016 Latency is exactly one cycle: y, y_valid, cur_ch reflect d and control sampled on the previous edge.
REQ-017 IDLE: y=0, y_valid=0, wrap=0; cur_ch and scan channel hold their values.
REQ-018 MANUAL: y=d[sel], cur_ch=sel, y_valid=1; if sel >= N_CH then y=0, y_valid=0, cur_ch=sel.
REQ-019 SCAN: y=d[scan channel], y_valid=1; dwell counter counts 0..DWELL-1, and on DWELL-1 the scan channel advances by one and the counter returns to 0.
REQ-020 Scan channel wraps N_CH-1 -> 0 (not 2^SW-1 -> 0); wrap asserts for the one cycle on which y first shows channel 0 after the wrap.
REQ-021 Entry into SCAN from MANUAL or IDLE: scan starts at the current sel if sel < N_CH, else at 0, with dwell counter 0; wrap is not asserted on entry.
REQ-022 DWELL=1: channel advances every cycle.
REQ-023 Leaving SCAN mid-dwell discards the dwell count; re-entry follows REQ-021.
REQ-024 d changes during a dwell appear on y one cycle later; the channel is not re-latched.

Reset
REQ-025 While reset=1 at an edge: state=IDLE, y=0, y_valid=0, cur_ch=0, wrap=0, scan channel=0, dwell counter=0.
REQ-026 Reset has priority over en, mode and every other input, including mid-dwell and on the wrap cycle.
REQ-027 First edge after reset deasserts: outputs follow REQ-015..REQ-021 with no additional delay.

Configuration
REQ-028 Macro SCAN_MUX_MASK_EN, when defined, adds input port ch_mask (N_CH bits, 1 = channel included in scan).
REQ-029 With SCAN_MUX_MASK_EN: the scan advances to the next set mask bit, skipping cleared ones within a single advance. Wrap asserts when the advance passes index N_CH-1. Scan entry at a masked sel goes to the next set bit. With ch_mask all zero: y=0, y_valid=0, wrap=0, and the state stays SCAN. MANUAL mode ignores ch_mask.
REQ-030 Without SCAN_MUX_MASK_EN: no ch_mask port; all N_CH channels are scanned.

Structure
REQ-031 Package scan_mux_pkg holds the state enum (IDLE, MANUAL, SCAN) and the mode constants MODE_MANUAL=0 and MODE_SCAN=1.
REQ-032 One sub-module, scan_mux_dwell_cnt (parameter DWELL), provides the dwell counter and an advance pulse; it is cleared on reset and on scan entry.

Verification
REQ-033 N_CH=8, W=8, d[k]=8'h10+k, en=1, mode=0, sel=5 -> next cycle y=8'h15, y_valid=1, cur_ch=5.
REQ-034 N_CH=6, mode=0, sel=7 -> y=0, y_valid=0.
REQ-035 N_CH=6, DWELL=3, mode=1 entered with sel=4 -> channels 4,4,4,5,5,5,0,... appear on y, and wrap=1 on the first cycle showing channel 0.
REQ-036 SCAN with DWELL=4, en dropped for 2 cycles mid-dwell -> y=0, y_valid=0 for those cycles; on re-entry with sel=2 the scan restarts at channel 2 with a full dwell.
REQ-037 reset=1 asserted on the wrap cycle -> next cycle all outputs 0, state IDLE; no wrap pulse is emitted.
REQ-038 SCAN_MUX_MASK_EN, N_CH=8, DWELL=1, ch_mask=8'b1000_0101 -> y cycles 0,2,7,0 with wrap on the return to 0; then ch_mask=0 -> y_valid=0.
